// File: rtl/change_dispenser.sv
// Change dispenser: returns change by greedy 25/10/5 coin ejection, one coin per clk_1Hz cycle.
// Optional REMAIN_BCD_EN adds registered BCD digits of the remaining amount.
module change_dispenser #(
    parameter int AMT_W    = 8,
    parameter int CNT_W    = 4,
    parameter int INIT_N5  = 8,
    parameter int INIT_N10 = 8,
    parameter int INIT_N25 = 8
) (
    input  logic             clk_1Hz,
    input  logic             clr,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             restock,
    input  logic [1:0]       restock_sel,
    output logic             coin5_out,
    output logic             coin10_out,
    output logic             coin25_out,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             err,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] n5,
    output logic [CNT_W-1:0] n10,
    output logic [CNT_W-1:0] n25
`ifdef REMAIN_BCD_EN
    ,
    output logic [3:0]       rem_bcd2,
    output logic [3:0]       rem_bcd1,
    output logic [3:0]       rem_bcd0
`endif
);

    typedef enum logic [1:0] {IDLE, DISPENSE, FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_nxt;
    logic               req_v;
    logic [AMT_W-1:0]   req_amt;
    logic [AMT_W-1:0]   rem_nxt;
    logic               pick5, pick10, pick25;
    logic               short_set, short_clr;
    logic               bad_amt, take_req;
    logic               inc5, inc10, inc25;

    assign bad_amt  = (change_amount % AMT_W'(5)) != '0;
    // A request is latched first and acted on the following cycle, so the
    // first coin lands two edges after start is sampled.
    assign take_req = (state == IDLE) && !req_v && start;

    assign inc5  = restock && (restock_sel == 2'd0);
    assign inc10 = restock && (restock_sel == 2'd1);
    assign inc25 = restock && (restock_sel == 2'd2);

    function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] n,
                                                  input logic inc, input logic dec);
        if (dec && !(inc && n != CNT_MAX)) return n - CNT_W'(1);
        if (inc && !dec && n != CNT_MAX)   return n + CNT_W'(1);
        return n;
    endfunction

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        pick5     = 1'b0;
        pick10    = 1'b0;
        pick25    = 1'b0;
        short_set = 1'b0;
        short_clr = 1'b0;
        case (state)
            IDLE: begin
                if (req_v) begin
                    state_nxt = DISPENSE;
                    rem_nxt   = req_amt;
                    short_clr = 1'b1;
                end
            end
            DISPENSE: begin
                if (remaining == '0) begin
                    state_nxt = FINISH;
                end else if (remaining >= AMT_W'(25) && n25 != '0) begin
                    pick25  = 1'b1;
                    rem_nxt = remaining - AMT_W'(25);
                end else if (remaining >= AMT_W'(10) && n10 != '0) begin
                    pick10  = 1'b1;
                    rem_nxt = remaining - AMT_W'(10);
                end else if (remaining >= AMT_W'(5) && n5 != '0) begin
                    pick5   = 1'b1;
                    rem_nxt = remaining - AMT_W'(5);
                end else begin
                    // no backtracking: whatever is left stays owed
                    short_set = 1'b1;
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            req_v      <= 1'b0;
            req_amt    <= '0;
            coin5_out  <= 1'b0;
            coin10_out <= 1'b0;
            coin25_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short      <= 1'b0;
            err        <= 1'b0;
            remaining  <= '0;
            n5         <= CNT_W'(INIT_N5);
            n10        <= CNT_W'(INIT_N10);
            n25        <= CNT_W'(INIT_N25);
        end else begin
            state      <= state_nxt;
            req_v      <= take_req && !bad_amt;
            err        <= take_req && bad_amt;
            if (take_req && !bad_amt) req_amt <= change_amount;
            coin5_out  <= pick5;
            coin10_out <= pick10;
            coin25_out <= pick25;
            busy       <= (state_nxt == DISPENSE);
            done       <= (state_nxt == FINISH);
            if (short_set)      short <= 1'b1;
            else if (short_clr) short <= 1'b0;
            remaining  <= rem_nxt;
            n5         <= inv_next(n5,  inc5,  pick5);
            n10        <= inv_next(n10, inc10, pick10);
            n25        <= inv_next(n25, inc25, pick25);
        end
    end

`ifdef REMAIN_BCD_EN
    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) begin
            rem_bcd2 <= '0;
            rem_bcd1 <= '0;
            rem_bcd0 <= '0;
        end else begin
            rem_bcd2 <= 4'(rem_nxt / AMT_W'(100));
            rem_bcd1 <= 4'((rem_nxt / AMT_W'(10)) % AMT_W'(10));
            rem_bcd0 <= 4'(rem_nxt % AMT_W'(10));
        end
    end
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Returns change to the customer after a sale: the outbound coin path, complementing the coin-accepting credit logic.
- Takes a change amount in cents, then ejects coins one per clk_1Hz cycle using a greedy largest-coin-first algorithm.
- Tracks its own 5/10/25-cent coin inventory.
- Reports done, short (cannot complete change) and the remaining amount to the display path.

Parameters:
- AMT_W, 8, width of the amount fields in cents.
- CNT_W, 4, width of each coin inventory counter; counters saturate at 2^CNT_W-1.
- INIT_N5, 8, inventory of 5c coins after reset.
- INIT_N10, 8, inventory of 10c coins after reset.
- INIT_N25, 8, inventory of 25c coins after reset.

Ports:
- clk_1Hz  in  1  slow system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  request to dispense change_amount; sampled only in IDLE.
- change_amount  in  AMT_W  change to return, in cents.
- restock  in  1  adds one coin of restock_sel to inventory this cycle.
- restock_sel  in  2  selects the coin: 0=5c, 1=10c, 2=25c, 3=ignored.
- coin5_out  out  1  one-cycle pulse: eject one 5c coin.
- coin10_out  out  1  one-cycle pulse: eject one 10c coin.
- coin25_out  out  1  one-cycle pulse: eject one 25c coin.
- busy  out  1  high in DISPENSE.
- done  out  1  one-cycle pulse when the transaction ends (either success or short).
- short  out  1  sticky; set when change could not be completed; cleared by the next accepted start.
- err  out  1  one-cycle pulse when change_amount is not a multiple of 5.
- remaining  out  AMT_W  change still owed.
- n5, n10, n25  out  CNT_W each  current inventory.

Behaviour:
- Reset (asynchronous, on clr high):
  - state=IDLE; all coin outputs, busy, done, short and err = 0; remaining=0.
  - n5/n10/n25 = INIT_N5/INIT_N10/INIT_N25.
  - Reset mid-dispense aborts immediately; coins already ejected are not credited back.
- All outputs are registered.
- At most one coinX_out is high in any cycle.
- States: IDLE, DISPENSE, FINISH.
- IDLE:
  - Invalid request, start=1 and change_amount%5 != 0: pulse err next cycle, stay IDLE, short unchanged.
  - Valid request, start=1 and change_amount%5 == 0: remaining<=change_amount, short<=0, go DISPENSE.
  - change_amount=0: go DISPENSE anyway; the first DISPENSE cycle sees remaining=0 and goes to FINISH with no coin.
- DISPENSE: each cycle, choose the first match in this order:
  - remaining=0 -> go FINISH.
  - remaining>=25 and n25>0 -> coin25_out=1, n25-=1, remaining-=25.
  - remaining>=10 and n10>0 -> coin10_out=1, n10-=1, remaining-=10.
  - remaining>=5 and n5>0 -> coin5_out=1, n5-=1, remaining-=5.
  - otherwise -> short<=1, go FINISH; remaining holds the unpaid amount.
- FINISH: done=1 for exactly one cycle, then IDLE. remaining holds its value until the next accepted start.
- Latency:
  - start sampled at edge k.
  - First coin pulse is high after edge k+2.
  - One coin per cycle thereafter.
  - done pulses the cycle after the final coin pulse (or the short decision).
- start while busy or in FINISH is ignored (no queueing).
- Restock:
  - Accepted in any state; the addressed counter increments, saturating at max.
  - Restock and dispense of the same coin in the same cycle: net change 0.
  - Restock at max plus dispense of the same coin: result max-1.
  - restock_sel=3: no effect.
- Greedy selection is not backtracked. Example: 30c with n25>0, n10=0, n5=0 gives 25c then short, remaining=5.

Optional Feature:
- Macro: REMAIN_BCD_EN.
- Defined:
  - Adds outputs rem_bcd2, rem_bcd1, rem_bcd0, 4 bits each: hundreds/tens/ones of remaining.
  - These are registered and update in the same cycle as remaining.
  - They feed the 7-segment digit controller directly.
- Undefined: these ports and their conversion logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start with amount=40, default inventory -> coin25, coin10, coin5 pulses on 3 consecutive cycles, then done; n25=n10=n5=7; remaining=0; short=0.
- INIT_N25=0, amount=30 -> coin10 on three consecutive cycles, then done; n10=5.
- INIT_N10=0, INIT_N5=0, amount=15 -> no coin pulses; short=1; done pulse; remaining=15.
- amount=7 -> err pulse; state stays IDLE; no coins; busy=0. Then amount=0 -> done pulse with no coins.
- Assert clr after the first coin pulse of amount=50 -> all outputs 0 and inventory=INIT values on the next cycle; a later start with amount=50 dispenses 25, 25.
- With n5=15 (CNT_W=4), restock 5c and dispense 5c in the same cycle -> n5=14. Under REMAIN_BCD_EN, amount=125 -> initial rem_bcd2/1/0 = 1/2/5.
